random_roll_display: RTL

//  Downstream consumer of the 5-bit LFSR random counter. On a debounced button press it samples the free-running

---
 rtl/random_roll_display_pkg.sv | 46 ++++
 rtl/random_roll_display_btn_debounce.sv | 59 +++++
 rtl/random_roll_display.sv | 130 +++++++++++++
 3 files changed

// File: rtl/random_roll_display_pkg.sv
// Shared definitions for the dice-roll display: FSM states, digit codes and
// active-low 7-segment glyphs (seg[0]=a .. seg[6]=g).
package random_roll_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REDUCE,
    ST_BCD,
    ST_DONE
  } state_e;

  // Digit-register codes: 0-9 are decimal digits, the rest are symbols
  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] code_to_seg(input logic [3:0] code);
    case (code)
      4'd0:      return SEG_0;
      4'd1:      return SEG_1;
      4'd2:      return SEG_2;
      4'd3:      return SEG_3;
      4'd4:      return SEG_4;
      4'd5:      return SEG_5;
      4'd6:      return SEG_6;
      4'd7:      return SEG_7;
      4'd8:      return SEG_8;
      4'd9:      return SEG_9;
      CODE_DASH: return SEG_DASH;
      default:   return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/random_roll_display_btn_debounce.sv
// Push-button conditioning: 2-flop synchronizer, stability counter and a
// one-cycle rise pulse on each accepted 0->1 level change.
module btn_debounce #(
  parameter int DB_LIMIT = 50000,
  parameter int DB_W     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic db_level_o,
  output logic rise_o
);

  localparam logic [DB_W-1:0] LIMIT_M1 = DB_W'(DB_LIMIT - 1);

  logic            sync1_q, sync2_q;
  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            rise_q, rise_d;

  // A sample that agrees with the accepted level restarts the stability count;
  // the level flips on the DB_LIMIT-th consecutive differing sample.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == LIMIT_M1) begin
      cnt_d   = '0;
      level_d = sync2_q;
      rise_d  = sync2_q;
    end else begin
      cnt_d = cnt_q + DB_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign db_level_o = level_q;
  assign rise_o     = rise_q;

endmodule

// File: rtl/random_roll_display.sv
// Samples the LFSR on a debounced press, reduces it to 1..RANGE with one
// subtract per cycle, splits it into BCD and scans it onto a 2-digit display.
module random_roll_display
  import random_roll_display_pkg::*;
#(
  parameter int RANGE    = 20,
  parameter int DB_LIMIT = 50000,
  parameter int DB_W     = 16,
  parameter int SCAN_W   = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic [4:0] rand_in,
  output logic       busy,
  output logic       roll_valid,
  output logic [4:0] roll_value,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam logic [5:0] RANGE_W = 6'(RANGE);

  logic              press;
  logic              db_level;
  state_e            state_q, state_d;
  logic [5:0]        work_q, work_d;
  logic [5:0]        ones_q, ones_d;
  logic [3:0]        tens_q, tens_d;
  logic [4:0]        roll_q, roll_d;
  logic [3:0]        disp_ones_q, disp_ones_d;
  logic [3:0]        disp_tens_q, disp_tens_d;
  logic [SCAN_W-1:0] scan_q;
  logic [6:0]        seg_q, seg_d;
  logic [1:0]        an_q, an_d;

  btn_debounce #(
    .DB_LIMIT(DB_LIMIT),
    .DB_W    (DB_W)
  ) u_debounce (
    .clk       (clk),
    .rst       (rst),
    .btn_i     (btn),
    .db_level_o(db_level),
    .rise_o    (press)
  );

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    ones_d      = ones_q;
    tens_d      = tens_q;
    roll_d      = roll_q;
    disp_ones_d = disp_ones_q;
    disp_tens_d = disp_tens_q;
    roll_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (press) begin
          work_d  = {1'b0, rand_in};
          state_d = ST_REDUCE;
        end
      end
      ST_REDUCE: begin
        if (work_q >= RANGE_W) begin
          work_d = work_q - RANGE_W;
        end else begin
          work_d  = work_q + 6'd1;
          ones_d  = work_q + 6'd1;
          tens_d  = 4'd0;
          state_d = ST_BCD;
        end
      end
      ST_BCD: begin
        if (ones_q >= 6'd10) begin
          ones_d = ones_q - 6'd10;
          tens_d = tens_q + 4'd1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        roll_valid  = 1'b1;
        roll_d      = work_q[4:0];
        disp_ones_d = ones_q[3:0];
        disp_tens_d = (tens_q == 4'd0) ? CODE_BLANK : tens_q;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Display path reads only the committed digit registers, never the BCD work regs
  always_comb begin
    an_d  = scan_q[SCAN_W-1] ? 2'b01 : 2'b10;
    seg_d = code_to_seg(scan_q[SCAN_W-1] ? disp_tens_q : disp_ones_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      work_q      <= '0;
      ones_q      <= '0;
      tens_q      <= '0;
      roll_q      <= '0;
      disp_ones_q <= CODE_DASH;
      disp_tens_q <= CODE_DASH;
      scan_q      <= '0;
      seg_q       <= SEG_DASH;
      an_q        <= 2'b10;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      ones_q      <= ones_d;
      tens_q      <= tens_d;
      roll_q      <= roll_d;
      disp_ones_q <= disp_ones_d;
      disp_tens_q <= disp_tens_d;
      scan_q      <= scan_q + SCAN_W'(1);
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign roll_value = roll_q;
  assign seg        = seg_q;
  assign an         = an_q;

endmodule
